vend_input_conditioner: RTL
===========================

# vend_input_conditioner

Front-end stage for the Basys 3 vending-machine FSM. It turns raw board inputs into the clean, single-cycle coin (`B`) and selection (`C`) codes that the FSM consumes:
- two coin-value switches plus an insert push-button;
- two product-select switches plus a buy push-button.

Each push-button is synchronized, debounced and edge-detected. The switch value is captured at the validated press. Outside a pulse, `B` and `C` read `2'b00` ("no coin" / `nada`).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal range ≥ 1.
- `SYNC_STAGES`, default 2: flip-flops in each input synchronizer. Legal range ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_coin`  in  2  coin value to insert: 1, 2 or 3 credits. 0 means no coin.
- `btn_insert`  in  1  raw insert push-button, active-high, bouncy.
- `sw_sel`  in  2  product select: 01 Pepsi, 10 Coca, 11 RedBull, 00 nada.
- `btn_buy`  in  1  raw buy push-button, active-high, bouncy.
- `B`  out  2  coin pulse to the FSM. Nonzero for exactly one cycle per accepted insert.
- `C`  out  2  selection pulse to the FSM. Nonzero for exactly one cycle per accepted buy.

## Operation
- All four switch bits and both buttons pass through `SYNC_STAGES`-deep synchronizers before any other use.
- Each button has its own debouncer with states LOCKED, IDLE, ARMING, HELD and a stability counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - **LOCKED (reset state):** the synced button must be low for `DEBOUNCE_CYCLES` consecutive cycles, then go to IDLE. Any high sample clears the counter. A button held through reset therefore never produces a pulse until it has been released.
  - **IDLE:** on a synced high, go to ARMING with the counter cleared.
  - **ARMING:** count consecutive high cycles.
    - A low sample returns to IDLE (bounce rejected).
    - When the count reaches `DEBOUNCE_CYCLES`, emit a one-cycle `press` and go to HELD.
  - **HELD:** count consecutive low cycles. When the count reaches `DEBOUNCE_CYCLES`, go to IDLE. A high sample clears the counter.
- **Insert press:** `B <= synced sw_coin` for one cycle. If `sw_coin` = 00, `B` stays 00 and the press is consumed.
- **Buy press:** `C <= synced sw_sel` for one cycle. `sw_sel` = 00 yields `C` = 00 and the press is consumed.
- **Simultaneous insert and buy press (same cycle):**
  - The coin is emitted first: `B` nonzero, `C` = 00.
  - The buy selection goes into a one-entry pending register and is emitted on the next cycle.
  - `B` and `C` are never nonzero in the same cycle.
- **Pending register:** a new buy press is impossible while it is occupied, because at least `DEBOUNCE_CYCLES` ≥ 1 release cycles are needed first. A coin press arriving in the cycle the pending buy is emitted wins again and defers the buy one more cycle.
- **Width rules:** the switch values are copied unchanged and no arithmetic is performed on them. The counters saturate at `DEBOUNCE_CYCLES` and never wrap.

## Timing
- **Reset:** asynchronous, active-high. While `reset` is high:
  - `B` = 00 and `C` = 00;
  - both debouncers are in LOCKED with counters at 0;
  - the pending register is empty;
  - the synchronizers are cleared to 0.
- **Reset mid-press:** any in-flight press or pending buy is discarded with no output.
- **Latency:** `B`/`C` goes nonzero `SYNC_STAGES + DEBOUNCE_CYCLES + 1` rising edges after the first edge that samples the raw button high, provided it stays high. A deferred buy adds 1 edge.
- **Captured value:** the switch value sent is the synced value in the cycle `press` asserts. Switch changes during ARMING are irrelevant before that point.
- **Outputs:** both are registered, with no combinational path from inputs to outputs. Each pulse lasts exactly 1 cycle, so the FSM sees each credit once.
- **Minimum spacing:** two accepted presses of the same button are at least `2*DEBOUNCE_CYCLES` cycles apart.

## Structure
- Shared package `vend_pkg`:
  - `coin_t` (2-bit, values 0–3 credits);
  - `product_t` enum {nada, Pepsi, Coca, RedBull};
  - `deb_state_t` enum {LOCKED, IDLE, ARMING, HELD}.
  - The FSM imports `product_t` from the same package.
- One sub-module, `btn_debouncer`:
  - contains the synchronizer and the 4-state debouncer, and outputs a one-cycle `press`;
  - is instantiated twice (insert, buy).
- The top level holds the switch synchronizers, the output registers and the pending-buy register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `SYNC_STAGES` = 2.
- **Clean insert:** `sw_coin` = 10, `btn_insert` high for 20 cycles from edge 0 → `B` = 10 exactly at edge 7 for one cycle, otherwise 00; `C` = 00 throughout.
- **Bounce rejection:** `btn_insert` toggles high 3 / low 1 repeatedly for 40 cycles, then steady high → no `B` pulse during the toggling; exactly one `B` pulse 7 edges after the steady high begins.
- **Simultaneous presses:** `sw_coin` = 01 and `sw_sel` = 11, both buttons rise on the same edge → `B` = 01 at edge 7, `C` = 11 at edge 8, never both nonzero together.
- **Held through reset:** `btn_buy` held high across reset deassertion for 50 cycles → `C` stays 00. After release for ≥ 6 cycles and a re-press, `C` = `sw_sel` appears once.
- **Reset mid-ARMING:** assert `reset` 3 cycles into ARMING → outputs 00 immediately; no pulse after release while the button is still held.
- **Zero values:** `sw_coin` = 00 with a valid insert press, and `sw_sel` = 00 with a valid buy press → `B` and `C` remain 00. A subsequent press with `sw_sel` = 01 yields `C` = 01 once.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending-machine front end and FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vend_pkg;

    // Coin value in credits: 0 (no coin) through 3.
    typedef logic [1:0] coin_t;

    // Product selection code consumed by the vending FSM.
    typedef enum logic [1:0] {
        nada    = 2'b00,
        Pepsi   = 2'b01,
        Coca    = 2'b10,
        RedBull = 2'b11
    } product_t;

    // Push-button debouncer states; LOCKED is entered from reset.
    typedef enum logic [1:0] {
        LOCKED = 2'b00,
        IDLE   = 2'b01,
        ARMING = 2'b10,
        HELD   = 2'b11
    } deb_state_t;

    localparam coin_t NO_COIN = 2'b00;

endpackage

// File: rtl/vend_input_conditioner_btn_debouncer.sv
// Synchronizes and debounces one raw push-button and emits a one-cycle press.
// Latency: press rises SYNC_STAGES + DEBOUNCE_CYCLES edges after the first high sample.
// Backpressure: none; the press is a fire-and-forget pulse.
module btn_debouncer
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    deb_state_t             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
    logic                   at_max;
    logic                   press_nxt;

    // Shift the raw button into the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end

    assign btn_s   = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + 1'b1;
    assign at_max  = (cnt_inc == CNT_MAX);

    // State, stability counter and registered press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOCKED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Next state: a level must hold for DEBOUNCE_CYCLES samples before it counts;
    // the counter is cleared on every transition so it never passes CNT_MAX.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOCKED: begin
                if (btn_s) begin
                    cnt_nxt = '0;
                end else if (at_max) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            IDLE: begin
                if (btn_s) begin
                    state_nxt = ARMING;
                    cnt_nxt   = '0;
                end
            end
            ARMING: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (at_max) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (btn_s) begin
                    cnt_nxt = '0;
                end else if (at_max) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = LOCKED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Press fires on the sample that completes a full stable-high run.
    always_comb begin
        press_nxt = (state == ARMING) && btn_s && at_max;
    end

endmodule

// File: rtl/vend_input_conditioner.sv
// Turns raw coin/buy buttons and switches into clean one-cycle B/C codes.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges from first high sample; deferred buy +1.
// Backpressure: none; a buy colliding with a coin waits in a one-entry pending register.
module vend_input_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_coin,
    input  logic       btn_insert,
    input  logic [1:0] sw_sel,
    input  logic       btn_buy,
    output logic [1:0] B,
    output logic [1:0] C
);

    logic [SYNC_STAGES-1:0][3:0] sw_q;
    coin_t                       coin_s;
    product_t                    sel_s;
    logic                        ins_press;
    logic                        buy_press;
    coin_t                       b_q;
    product_t                    c_q;
    logic                        pend_vld;
    product_t                    pend_dat;

    // Synchronize all four switch bits together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sw_q <= '0;
        else       sw_q <= {sw_q[SYNC_STAGES-2:0], sw_coin, sw_sel};
    end

    assign coin_s = coin_t'(sw_q[SYNC_STAGES-1][3:2]);
    assign sel_s  = product_t'(sw_q[SYNC_STAGES-1][1:0]);

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_deb_insert (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_insert),
        .press (ins_press)
    );

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_deb_buy (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_buy),
        .press (buy_press)
    );

    // Output pulses: coin always wins a collision, a buy that loses is parked
    // and replayed the first cycle no coin press competes with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q      <= NO_COIN;
            c_q      <= nada;
            pend_vld <= 1'b0;
            pend_dat <= nada;
        end else begin
            b_q <= NO_COIN;
            c_q <= nada;
            if (ins_press) begin
                b_q <= coin_s;
                if (buy_press) begin
                    pend_vld <= 1'b1;
                    pend_dat <= sel_s;
                end
            end else if (pend_vld) begin
                c_q      <= pend_dat;
                pend_vld <= buy_press;
                if (buy_press) pend_dat <= sel_s;
            end else if (buy_press) begin
                c_q <= sel_s;
            end
        end
    end

    assign B = b_q;
    assign C = c_q;

endmodule
